regstrb2mem_multi: RTL and testbench

REGSTRB2MEM_MULTI -- requirements
Module: regstrb2mem_multi

---
 rtl/regstrb2mem_multi.sv | 120 ++++++++++++
 tb/tb_regstrb2mem_multi.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regstrb2mem_multi.sv
// regstrb2mem_multi
// Collects 32-bit register lanes written by independent one-cycle strobes and
// commits them as a single wide instruction word into a code memory.
//
// Ports
//   clk              : single clock, rising edge
//   rst              : synchronous active-high reset
//   lane_value       : register values, lane i at [32i+31:32i]
//   lane_strobe      : one-cycle write strobe per lane
//   control_start    : restart loading (pointer, partial word, error flags)
//   code_mem_wr_addr : write address, holds last-written value between writes
//   code_mem_wr_data : assembled word, holds last-written value between writes
//   code_mem_wr_en   : one-cycle write enable
//   inst_count       : words written since last start/reset, saturating
//   full             : inst_count has reached memory depth
//   dup_err          : sticky, a lane was strobed twice before commit
//   ovf_err          : sticky, a word completed while full and was dropped
module regstrb2mem_multi #(
  parameter int ADDR_WIDTH = 10,
  parameter int LANES      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [32*LANES-1:0]     lane_value,
  input  logic [LANES-1:0]        lane_strobe,
  input  logic                    control_start,
  output logic [ADDR_WIDTH-1:0]   code_mem_wr_addr,
  output logic [32*LANES-1:0]     code_mem_wr_data,
  output logic                    code_mem_wr_en,
  output logic [ADDR_WIDTH:0]     inst_count,
  output logic                    full,
  output logic                    dup_err,
  output logic                    ovf_err
);

  localparam int DW = 32 * LANES;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DW-1:0]         hold_q, hold_d;
  logic [LANES-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  dup_q, dup_d;
  logic                  ovf_q, ovf_d;
  logic                  complete;

  assign full     = (cnt_q == DEPTH);
  // A lane counts toward completion if it is already held or arrives now.
  assign complete = &(valid_q | lane_strobe);

  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    dup_d   = dup_q;
    ovf_d   = ovf_q;
    if (control_start) begin
      valid_d = '0;
      cnt_d   = '0;
      dup_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_strobe[i]) begin
          hold_d[32*i +: 32] = lane_value[32*i +: 32];
          valid_d[i]         = 1'b1;
          if (valid_q[i]) dup_d = 1'b1;
        end
      end
      if (complete) begin
        // hold_d already carries this cycle's strobed values, so the
        // final lane needs no extra cycle to be captured.
        valid_d = '0;
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          data_d  = hold_d;
          cnt_d   = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      dup_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      dup_q   <= dup_d;
      ovf_q   <= ovf_d;
    end
  end

  assign code_mem_wr_addr = addr_q;
  assign code_mem_wr_data = data_q;
  assign code_mem_wr_en   = wr_en_q;
  assign inst_count       = cnt_q;
  assign dup_err          = dup_q;
  assign ovf_err          = ovf_q;

endmodule

// File: tb/tb_regstrb2mem_multi.sv
// Scoreboarded bench for regstrb2mem_multi. Four instances with different
// geometries are driven one at a time; the reference model queues expected
// writes and a negedge monitor checks every write enable against the queue.
module tb_regstrb2mem_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: AW=2 LN=2, 1: AW=3 LN=4, 2: AW=2 LN=1, 3: defaults
  int LN[4] = '{2, 4, 1, 2};
  int AW[4] = '{2, 3, 2, 10};

  logic [63:0]  lv0;  logic [1:0] ls0; logic st0, rst0;
  logic [127:0] lv1;  logic [3:0] ls1; logic st1, rst1;
  logic [31:0]  lv2;  logic [0:0] ls2; logic st2, rst2;
  logic [63:0]  lv3;  logic [1:0] ls3; logic st3, rst3;

  logic [1:0] wa0; logic [63:0]  wd0; logic we0; logic [2:0]  ic0; logic fu0, de0, oe0;
  logic [2:0] wa1; logic [127:0] wd1; logic we1; logic [3:0]  ic1; logic fu1, de1, oe1;
  logic [1:0] wa2; logic [31:0]  wd2; logic we2; logic [2:0]  ic2; logic fu2, de2, oe2;
  logic [9:0] wa3; logic [63:0]  wd3; logic we3; logic [10:0] ic3; logic fu3, de3, oe3;

  regstrb2mem_multi #(.ADDR_WIDTH(2), .LANES(2)) u0 (
    .clk(clk), .rst(rst0), .lane_value(lv0), .lane_strobe(ls0), .control_start(st0),
    .code_mem_wr_addr(wa0), .code_mem_wr_data(wd0), .code_mem_wr_en(we0),
    .inst_count(ic0), .full(fu0), .dup_err(de0), .ovf_err(oe0));
  regstrb2mem_multi #(.ADDR_WIDTH(3), .LANES(4)) u1 (
    .clk(clk), .rst(rst1), .lane_value(lv1), .lane_strobe(ls1), .control_start(st1),
    .code_mem_wr_addr(wa1), .code_mem_wr_data(wd1), .code_mem_wr_en(we1),
    .inst_count(ic1), .full(fu1), .dup_err(de1), .ovf_err(oe1));
  regstrb2mem_multi #(.ADDR_WIDTH(2), .LANES(1)) u2 (
    .clk(clk), .rst(rst2), .lane_value(lv2), .lane_strobe(ls2), .control_start(st2),
    .code_mem_wr_addr(wa2), .code_mem_wr_data(wd2), .code_mem_wr_en(we2),
    .inst_count(ic2), .full(fu2), .dup_err(de2), .ovf_err(oe2));
  regstrb2mem_multi u3 (
    .clk(clk), .rst(rst3), .lane_value(lv3), .lane_strobe(ls3), .control_start(st3),
    .code_mem_wr_addr(wa3), .code_mem_wr_data(wd3), .code_mem_wr_en(we3),
    .inst_count(ic3), .full(fu3), .dup_err(de3), .ovf_err(oe3));

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input int k, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic set_in(input int k, input logic [127:0] v, input logic [3:0] s,
                        input logic st, input logic r);
    case (k)
      0: begin lv0 = v[63:0]; ls0 = s[1:0]; st0 = st; rst0 = r; end
      1: begin lv1 = v;       ls1 = s;      st1 = st; rst1 = r; end
      2: begin lv2 = v[31:0]; ls2 = s[0:0]; st2 = st; rst2 = r; end
      default: begin lv3 = v[63:0]; ls3 = s[1:0]; st3 = st; rst3 = r; end
    endcase
  endtask

  task automatic get_out(input int k, output logic we, output logic [9:0] a,
                         output logic [127:0] d, output logic [10:0] c,
                         output logic f, output logic de, output logic oe);
    case (k)
      0: begin we = we0; a = 10'(wa0); d = 128'(wd0); c = 11'(ic0); f = fu0; de = de0; oe = oe0; end
      1: begin we = we1; a = 10'(wa1); d = wd1;       c = 11'(ic1); f = fu1; de = de1; oe = oe1; end
      2: begin we = we2; a = 10'(wa2); d = 128'(wd2); c = 11'(ic2); f = fu2; de = de2; oe = oe2; end
      default: begin we = we3; a = wa3; d = 128'(wd3); c = ic3; f = fu3; de = de3; oe = oe3; end
    endcase
  endtask

  // Reference model: a set of held lanes per instance; a word is emitted when
  // every lane has been supplied since the last commit.
  typedef struct { int k; int cyc; logic [9:0] a; logic [127:0] d; } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_hold[4][4];
  bit          m_vld[4][4];
  int          m_cnt[4];
  bit          m_dup[4], m_ovf[4];
  logic [9:0]   ml_a[4];
  logic [127:0] ml_d[4];

  task automatic model(input int k, input logic [127:0] v, input logic [3:0] s,
                       input logic st, input logic r);
    bit all;
    exp_t e;
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_hold[k][i] = 0; m_vld[k][i] = 0; end
      m_cnt[k] = 0; m_dup[k] = 0; m_ovf[k] = 0;
      return;
    end
    if (st) begin
      for (int i = 0; i < 4; i++) m_vld[k][i] = 0;
      m_cnt[k] = 0; m_dup[k] = 0; m_ovf[k] = 0;
      return;
    end
    all = 1;
    for (int i = 0; i < LN[k]; i++) begin
      if (s[i]) begin
        if (m_vld[k][i]) m_dup[k] = 1;
        m_hold[k][i] = v[32*i +: 32];
        m_vld[k][i]  = 1;
      end
      if (!m_vld[k][i]) all = 0;
    end
    if (all) begin
      for (int i = 0; i < 4; i++) m_vld[k][i] = 0;
      if (m_cnt[k] == (1 << AW[k])) begin
        m_ovf[k] = 1;
      end else begin
        e.k = k; e.cyc = cyc + 1;
        e.a = 10'(m_cnt[k] % (1 << AW[k]));
        e.d = '0;
        for (int i = 0; i < LN[k]; i++) e.d[32*i +: 32] = m_hold[k][i];
        exp_q.push_back(e);
        m_cnt[k]++;
      end
    end
  endtask

  task automatic chk_state(input int k);
    logic we, f, de, oe; logic [9:0] a; logic [127:0] d; logic [10:0] c;
    get_out(k, we, a, d, c, f, de, oe);
    check("inst_count", k, 128'(c), 128'(m_cnt[k]));
    check("full", k, 128'(f), 128'(m_cnt[k] == (1 << AW[k])));
    check("dup_err", k, 128'(de), 128'(m_dup[k]));
    check("ovf_err", k, 128'(oe), 128'(m_ovf[k]));
  endtask

  task automatic step(input int k, input logic [127:0] v, input logic [3:0] s,
                      input logic st, input logic r);
    set_in(k, v, s, st, r);
    model(k, v, s, st, r);
    @(posedge clk);
    #1;
    set_in(k, '0, '0, 1'b0, 1'b0);
    if (r) begin ml_a[k] = '0; ml_d[k] = '0; end
    chk_state(k);
  endtask

  // Direct spot check of the write port right after the last step.
  task automatic chk_wr(input string nm, input int k, input logic we_exp,
                        input logic [9:0] a_exp, input logic [127:0] d_exp);
    logic we, f, de, oe; logic [9:0] a; logic [127:0] d; logic [10:0] c;
    get_out(k, we, a, d, c, f, de, oe);
    check({nm, "_we"}, k, 128'(we), 128'(we_exp));
    if (we_exp) begin
      check({nm, "_addr"}, k, 128'(a), 128'(a_exp));
      check({nm, "_data"}, k, d, d_exp);
    end
  endtask

  bit mon_en = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 4; k++) begin
        logic we, f, de, oe; logic [9:0] a; logic [127:0] d; logic [10:0] c;
        exp_t e;
        get_out(k, we, a, d, c, f, de, oe);
        if (we) begin
          if (exp_q.size() == 0 || exp_q[0].k != k) begin
            check("unexpected_write", k, 128'(we), 128'(0));
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", k, 128'(a), 128'(e.a));
            check("wr_data", k, d, e.d);
            check("wr_cycle", k, 128'(cyc), 128'(e.cyc));
            ml_a[k] = e.a;
            ml_d[k] = e.d;
          end
        end else begin
          check("hold_addr", k, 128'(a), 128'(ml_a[k]));
          check("hold_data", k, d, ml_d[k]);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      set_in(k, '0, '0, 1'b0, 1'b1);
      model(k, '0, '0, 1'b0, 1'b1);
      ml_a[k] = '0; ml_d[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) set_in(k, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk_state(k);
      chk_wr("reset", k, 1'b0, '0, '0);
    end
    mon_en = 1;

    // split strobes, default geometry
    step(3, 128'hDEADBEEF_00000000, 4'b0010, 0, 0);
    chk_wr("split_first", 3, 1'b0, '0, '0);
    step(3, 128'h12345678, 4'b0001, 0, 0);
    chk_wr("split", 3, 1'b1, 10'd0, 128'hDEADBEEF_12345678);
    check("split_count", 3, 128'(ic3), 128'd1);

    // back-to-back full words
    step(0, '0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 128'h0000000B_0000000A, 4'b0011, 0, 0);
      chk_wr("b2b", 0, 1'b1, 10'(i), 128'h0000000B_0000000A);
    end

    // duplicate strobe on lane 0
    step(0, '0, '0, 1, 0);
    step(0, 128'h1, 4'b0001, 0, 0);
    step(0, 128'h2, 4'b0001, 0, 0);
    step(0, 128'h00000003_00000000, 4'b0010, 0, 0);
    chk_wr("dup", 0, 1'b1, 10'd0, 128'h00000003_00000002);
    check("dup_flag", 0, 128'(de0), 128'd1);

    // fill and overflow a 4-deep memory
    step(0, '0, '0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, {96'(i + 100), 32'(i)}, 4'b0011, 0, 0);
      if (i == 3) check("full_after4", 0, 128'(fu0), 128'd1);
    end
    chk_wr("ovf_drop", 0, 1'b0, '0, '0);
    check("ovf_flag", 0, 128'(oe0), 128'd1);
    check("ovf_count", 0, 128'(ic0), 128'd4);

    // start beats completion and clears errors
    step(0, 128'h5, 4'b0001, 0, 0);
    step(0, 128'h6, 4'b0001, 0, 0);
    step(0, 128'h00000007_00000000, 4'b0010, 1, 0);
    chk_wr("start_prio", 0, 1'b0, '0, '0);
    check("start_count", 0, 128'(ic0), 128'd0);
    check("start_dup", 0, 128'(de0), 128'd0);
    check("start_ovf", 0, 128'(oe0), 128'd0);
    step(0, 128'h00000009_00000008, 4'b0011, 0, 0);
    chk_wr("after_start", 0, 1'b1, 10'd0, 128'h00000009_00000008);

    // four lanes out of order, then reset mid-word
    step(1, '0, '0, 1, 0);
    step(1, 128'h33333333_00000000_00000000_00000000, 4'b1000, 0, 0);
    step(1, 128'h00000000_00000000_00000000_00000000, 4'b0001, 0, 0);
    step(1, 128'h00000000_22222222_00000000_00000000, 4'b0100, 0, 0);
    chk_wr("ooo_wait", 1, 1'b0, '0, '0);
    step(1, 128'h00000000_00000000_11111111_00000000, 4'b0010, 0, 0);
    chk_wr("ooo", 1, 1'b1, 10'd0, 128'h33333333_22222222_11111111_00000000);
    step(1, 128'hAAAA, 4'b0001, 0, 0);
    step(1, 128'h0, 4'b0110, 0, 0);
    step(1, 128'hFFFFFFFF_0, 4'b1000, 0, 1);
    chk_wr("rst_mid", 1, 1'b0, '0, '0);
    step(1, 128'hBBBBBBBB_00000000_00000000_00000000, 4'b1000, 0, 0);
    chk_wr("rst_discard", 1, 1'b0, '0, '0);

    // single lane commits each strobe
    step(2, '0, '0, 1, 0);
    step(2, 128'hCAFE0001, 4'b0001, 0, 0);
    chk_wr("one_lane", 2, 1'b1, 10'd0, 128'hCAFE0001);
    step(2, 128'hCAFE0002, 4'b0001, 0, 0);
    chk_wr("one_lane2", 2, 1'b1, 10'd1, 128'hCAFE0002);
    check("one_lane_dup", 2, 128'(de2), 128'd0);

    // randomized traffic on every instance
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 200; n++) begin
        logic [3:0] s;
        s = 4'($urandom) & 4'((1 << LN[k]) - 1);
        if ($urandom_range(3) == 0) s = '0;
        step(k, {$urandom, $urandom, $urandom, $urandom}, s,
             1'($urandom_range(29) == 0), 1'($urandom_range(79) == 0));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("pending_writes", 0, 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
